// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus: ID/EX hazard inputs, memory/branch events, per-stage
// write enables, flush controls and statistics.
interface pipe_hazard_ctrl_if #(
    parameter int W = 5
);
    logic         id_valid;
    logic         id_uses_rs;
    logic         id_uses_rt;
    logic [W-1:0] id_rs;
    logic [W-1:0] id_rt;
    logic         ex_MemRead;
    logic [W-1:0] ex_rt;
    logic         branch_taken;
    logic         mem_busy;

    logic         pc_write;
    logic         if_id_write;
    logic         id_ex_write;
    logic         ex_mem_write;
    logic         mem_wb_write;
    logic         if_id_flush;
    logic         id_ex_bubble;
    logic         ex_mem_flush;
    logic [1:0]   state;
    logic [15:0]  stall_cnt;
    logic [15:0]  flush_cnt;

    modport master (
        output id_valid, id_uses_rs, id_uses_rt, id_rs, id_rt,
               ex_MemRead, ex_rt, branch_taken, mem_busy,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_bubble, ex_mem_flush, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_uses_rs, id_uses_rt, id_rs, id_rt,
               ex_MemRead, ex_rt, branch_taken, mem_busy,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_bubble, ex_mem_flush, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and memory-busy
// freezes, with saturating stall/flush statistics.
module pipe_hazard_ctrl #(
    parameter int W          = 5,
    parameter int LOAD_STALL = 1
) (
    input logic             clk,
    input logic             rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        FREEZE = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_flush;
    } ctl_t;

    localparam ctl_t CTL_NORMAL = ctl_t'(8'hF8);
    localparam ctl_t CTL_FROZEN = ctl_t'(8'h00);
    localparam ctl_t CTL_STALL  = ctl_t'(8'h3A);
    localparam ctl_t CTL_FLUSH  = ctl_t'(8'hFF);

    localparam logic [W-1:0] ZERO_REG = '0;
    localparam logic [2:0]   INIT_CNT = 3'(LOAD_STALL - 1);

    state_e     cur_q, nxt_d, ret_q, ret_d;
    logic [2:0] cnt_q, cnt_d;
    ctl_t       ctl;
    logic       load_use;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign load_use = hz.ex_MemRead & hz.id_valid & (hz.ex_rt != ZERO_REG) &
                      ((hz.id_uses_rs & (hz.ex_rt == hz.id_rs)) |
                       (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= RUN;
            ret_q <= RUN;
            cnt_q <= 3'd0;
        end else begin
            cur_q <= nxt_d;
            ret_q <= ret_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        nxt_d = cur_q;
        ret_d = ret_q;
        cnt_d = cnt_q;
        ctl   = CTL_NORMAL;
        unique case (cur_q)
            RUN: begin
                if (hz.mem_busy) begin
                    ctl   = CTL_FROZEN;
                    nxt_d = FREEZE;
                    ret_d = RUN;
                end else if (hz.branch_taken) begin
                    ctl   = CTL_FLUSH;
                    nxt_d = RUN;
                end else if (load_use) begin
                    ctl = CTL_STALL;
                    if (LOAD_STALL > 1) begin
                        nxt_d = BUBBLE;
                        cnt_d = INIT_CNT;
                    end
                end
            end
            BUBBLE: begin
                if (hz.mem_busy) begin
                    ctl   = CTL_FROZEN;
                    nxt_d = FREEZE;
                    ret_d = BUBBLE;
                end else if (hz.branch_taken) begin
                    ctl   = CTL_FLUSH;
                    nxt_d = RUN;
                    cnt_d = 3'd0;
                end else begin
                    // Remaining bubbles are owed regardless of a new load-use.
                    ctl   = CTL_STALL;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) nxt_d = RUN;
                end
            end
            FREEZE: begin
                ctl = CTL_FROZEN;
                if (!hz.mem_busy) nxt_d = ret_q;
            end
            default: begin
                ctl   = CTL_FROZEN;
                nxt_d = RUN;
            end
        endcase
        if (!rst_n) ctl = CTL_FROZEN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz.stall_cnt <= 16'd0;
            hz.flush_cnt <= 16'd0;
        end else begin
            if (!ctl.pc_write && hz.stall_cnt != 16'hFFFF)
                hz.stall_cnt <= hz.stall_cnt + 16'd1;
            if (ctl.ex_mem_flush && hz.flush_cnt != 16'hFFFF)
                hz.flush_cnt <= hz.flush_cnt + 16'd1;
        end
    end

    assign hz.pc_write     = ctl.pc_write;
    assign hz.if_id_write  = ctl.if_id_write;
    assign hz.id_ex_write  = ctl.id_ex_write;
    assign hz.ex_mem_write = ctl.ex_mem_write;
    assign hz.mem_wb_write = ctl.mem_wb_write;
    assign hz.if_id_flush  = ctl.if_id_flush;
    assign hz.id_ex_bubble = ctl.id_ex_bubble;
    assign hz.ex_mem_flush = ctl.ex_mem_flush;
    assign hz.state        = cur_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios on LOAD_STALL=1 and =3
// instances plus a randomized run against a remaining-bubbles model.
module tb_pipe_hazard_ctrl;
    localparam logic [7:0] NORMAL = 8'hF8;
    localparam logic [7:0] FROZEN = 8'h00;
    localparam logic [7:0] STALL  = 8'h3A;
    localparam logic [7:0] FLUSH  = 8'hFF;

    typedef struct packed {
        logic       id_valid;
        logic       uses_rs;
        logic       uses_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic       busy;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.W(5)) bus_a ();
    pipe_hazard_ctrl_if #(.W(5)) bus_b ();

    pipe_hazard_ctrl #(.W(5), .LOAD_STALL(1)) dut_a (.clk(clk), .rst_n(rst_n), .hz(bus_a));
    pipe_hazard_ctrl #(.W(5), .LOAD_STALL(3)) dut_b (.clk(clk), .rst_n(rst_n), .hz(bus_b));

    logic [7:0] ctl_a, ctl_b;
    assign ctl_a = {bus_a.pc_write, bus_a.if_id_write, bus_a.id_ex_write, bus_a.ex_mem_write,
                    bus_a.mem_wb_write, bus_a.if_id_flush, bus_a.id_ex_bubble, bus_a.ex_mem_flush};
    assign ctl_b = {bus_b.pc_write, bus_b.if_id_write, bus_b.id_ex_write, bus_b.ex_mem_write,
                    bus_b.mem_wb_write, bus_b.if_id_flush, bus_b.id_ex_bubble, bus_b.ex_mem_flush};

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t lu_stim();
        stim_t s;
        s = '0;
        s.id_valid = 1'b1;
        s.uses_rs  = 1'b1;
        s.rs       = 5'd5;
        s.memread  = 1'b1;
        s.ex_rt    = 5'd5;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus_a.id_valid = s.id_valid;  bus_b.id_valid = s.id_valid;
        bus_a.id_uses_rs = s.uses_rs; bus_b.id_uses_rs = s.uses_rs;
        bus_a.id_uses_rt = s.uses_rt; bus_b.id_uses_rt = s.uses_rt;
        bus_a.id_rs = s.rs;           bus_b.id_rs = s.rs;
        bus_a.id_rt = s.rt;           bus_b.id_rt = s.rt;
        bus_a.ex_MemRead = s.memread; bus_b.ex_MemRead = s.memread;
        bus_a.ex_rt = s.ex_rt;        bus_b.ex_rt = s.ex_rt;
        bus_a.branch_taken = s.br;    bus_b.branch_taken = s.br;
        bus_a.mem_busy = s.busy;      bus_b.mem_busy = s.busy;
    endtask

    // Inputs change after the falling edge; outputs are sampled 1 ns later.
    task automatic tick(input stim_t s);
        @(negedge clk);
        drive(s);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(idle());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(idle());
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (ctl_a !== FROZEN || ctl_b !== FROZEN) begin
            bad++; $display("FAIL reset_ctl: got %h/%h want %h", ctl_a, ctl_b, FROZEN);
        end
        total++;
        if (bus_a.state !== 2'd0 || bus_b.state !== 2'd0) begin
            bad++; $display("FAIL reset_state: got %0d/%0d want 0", bus_a.state, bus_b.state);
        end
        total++;
        if (bus_a.stall_cnt !== 16'd0 || bus_a.flush_cnt !== 16'd0 ||
            bus_b.stall_cnt !== 16'd0 || bus_b.flush_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_cnt: got %h %h %h %h want 0", bus_a.stall_cnt,
                            bus_a.flush_cnt, bus_b.stall_cnt, bus_b.flush_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        apply_reset();
        tick(lu_stim());
        total++;
        if (ctl_a !== STALL) begin
            bad++; $display("FAIL lu1_stall: got %h want %h", ctl_a, STALL);
        end
        tick(idle());
        total++;
        if (ctl_a !== NORMAL || bus_a.state !== 2'd0) begin
            bad++; $display("FAIL lu1_after: got %h st %0d want %h st 0", ctl_a, bus_a.state, NORMAL);
        end
        total++;
        if (bus_a.stall_cnt !== 16'd1) begin
            bad++; $display("FAIL lu1_stall_cnt: got %0d want 1", bus_a.stall_cnt);
        end
    endtask

    task automatic test_zero_reg();
        stim_t s;
        apply_reset();
        s = lu_stim();
        s.ex_rt = 5'd0;
        s.rs    = 5'd0;
        tick(s);
        total++;
        if (ctl_a !== NORMAL || ctl_b !== NORMAL) begin
            bad++; $display("FAIL zero_reg_ctl: got %h/%h want %h", ctl_a, ctl_b, NORMAL);
        end
        tick(idle());
        total++;
        if (bus_a.stall_cnt !== 16'd0 || bus_b.stall_cnt !== 16'd0) begin
            bad++; $display("FAIL zero_reg_cnt: got %0d/%0d want 0", bus_a.stall_cnt, bus_b.stall_cnt);
        end
    endtask

    task automatic test_load_stall3();
        logic [7:0] ec [4];
        logic [1:0] es [4];
        ec = '{STALL, STALL, STALL, NORMAL};
        es = '{2'd0, 2'd1, 2'd1, 2'd0};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            tick(i == 0 ? lu_stim() : idle());
            total++;
            if (ctl_b !== ec[i] || bus_b.state !== es[i]) begin
                bad++; $display("FAIL ls3_cyc%0d: got %h st %0d want %h st %0d",
                                i, ctl_b, bus_b.state, ec[i], es[i]);
            end
        end
        total++;
        if (bus_b.stall_cnt !== 16'd3) begin
            bad++; $display("FAIL ls3_stall_cnt: got %0d want 3", bus_b.stall_cnt);
        end
    endtask

    task automatic test_branch_priority();
        stim_t s;
        apply_reset();
        s = lu_stim();
        s.br = 1'b1;
        tick(s);
        total++;
        if (ctl_a !== FLUSH || ctl_b !== FLUSH) begin
            bad++; $display("FAIL br_ctl: got %h/%h want %h", ctl_a, ctl_b, FLUSH);
        end
        tick(idle());
        total++;
        if (ctl_b !== NORMAL || bus_b.state !== 2'd0) begin
            bad++; $display("FAIL br_after: got %h st %0d want %h st 0", ctl_b, bus_b.state, NORMAL);
        end
        total++;
        if (bus_b.flush_cnt !== 16'd1 || bus_b.stall_cnt !== 16'd0) begin
            bad++; $display("FAIL br_cnt: got flush %0d stall %0d want 1 0", bus_b.flush_cnt, bus_b.stall_cnt);
        end
    endtask

    task automatic test_busy_in_bubble();
        stim_t      s;
        logic [7:0] ec [9];
        logic [1:0] es [9];
        ec = '{STALL, FROZEN, FROZEN, FROZEN, FROZEN, FROZEN, STALL, STALL, NORMAL};
        es = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 0) s = lu_stim();
            else if (i <= 4) begin
                // branch and load-use ride along to confirm busy dominates them
                s = lu_stim();
                s.busy = 1'b1;
                s.br   = 1'b1;
            end else s = idle();
            tick(s);
            total++;
            if (ctl_b !== ec[i] || bus_b.state !== es[i]) begin
                bad++; $display("FAIL busy_bub_cyc%0d: got %h st %0d want %h st %0d",
                                i, ctl_b, bus_b.state, ec[i], es[i]);
            end
        end
        total++;
        if (bus_b.stall_cnt !== 16'd8 || bus_b.flush_cnt !== 16'd0) begin
            bad++; $display("FAIL busy_bub_cnt: got stall %0d flush %0d want 8 0",
                            bus_b.stall_cnt, bus_b.flush_cnt);
        end
    endtask

    task automatic test_reset_mid_freeze();
        stim_t s;
        apply_reset();
        s = idle();
        s.busy = 1'b1;
        tick(s);
        tick(s);
        total++;
        if (bus_a.state !== 2'd2) begin
            bad++; $display("FAIL rmf_pre_state: got %0d want 2", bus_a.state);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (ctl_a !== FROZEN || bus_a.state !== 2'd0 || bus_a.stall_cnt !== 16'd0 || bus_a.flush_cnt !== 16'd0) begin
            bad++; $display("FAIL rmf_in_reset: got %h st %0d cnt %0d/%0d want %h st 0 cnt 0/0",
                            ctl_a, bus_a.state, bus_a.stall_cnt, bus_a.flush_cnt, FROZEN);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(idle());
        #1;
        total++;
        if (ctl_a !== NORMAL || bus_a.state !== 2'd0) begin
            bad++; $display("FAIL rmf_release: got %h st %0d want %h st 0", ctl_a, bus_a.state, NORMAL);
        end
        tick(idle());
        total++;
        if (ctl_a !== NORMAL || bus_a.stall_cnt !== 16'd0) begin
            bad++; $display("FAIL rmf_after: got %h cnt %0d want %h cnt 0", ctl_a, bus_a.stall_cnt, NORMAL);
        end
    endtask

    // Model: bubbles still owed, a frozen flag, and running event tallies.
    task automatic test_random();
        int         left [2];
        bit         frz [2];
        int         sc [2];
        int         fc [2];
        int         ls;
        bit         lu;
        stim_t      s;
        logic [7:0] e, oc;
        logic [1:0] es, os;
        logic [15:0] osc, ofc;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            left[k] = 0; frz[k] = 0; sc[k] = 0; fc[k] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            s = '0;
            s.id_valid = ($urandom_range(0, 3) != 0);
            s.uses_rs  = 1'($urandom_range(0, 1));
            s.uses_rt  = 1'($urandom_range(0, 1));
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.memread  = 1'($urandom_range(0, 1));
            s.ex_rt    = 5'($urandom_range(0, 3));
            s.br       = ($urandom_range(0, 7) == 0);
            s.busy     = ($urandom_range(0, 6) == 0) || (frz[0] && $urandom_range(0, 1) == 1);
            tick(s);
            lu = s.memread && s.id_valid && s.ex_rt != 0 &&
                 ((s.uses_rs && s.ex_rt == s.rs) || (s.uses_rt && s.ex_rt == s.rt));
            for (int k = 0; k < 2; k++) begin
                ls  = (k == 0) ? 1 : 3;
                oc  = (k == 0) ? ctl_a : ctl_b;
                os  = (k == 0) ? bus_a.state : bus_b.state;
                osc = (k == 0) ? bus_a.stall_cnt : bus_b.stall_cnt;
                ofc = (k == 0) ? bus_a.flush_cnt : bus_b.flush_cnt;
                es  = frz[k] ? 2'd2 : (left[k] > 0 ? 2'd1 : 2'd0);
                if (frz[k]) begin
                    e = FROZEN;
                    if (!s.busy) frz[k] = 0;
                end else if (s.busy) begin
                    e = FROZEN;
                    frz[k] = 1;
                end else if (s.br) begin
                    e = FLUSH;
                    left[k] = 0;
                end else if (left[k] > 0) begin
                    e = STALL;
                    left[k]--;
                end else if (lu) begin
                    e = STALL;
                    left[k] = ls - 1;
                end else e = NORMAL;
                total++;
                if (oc !== e) begin
                    bad++; $display("FAIL rand_ctl n=%0d dut%0d: got %h want %h", n, k, oc, e);
                end
                total++;
                if (os !== es) begin
                    bad++; $display("FAIL rand_state n=%0d dut%0d: got %0d want %0d", n, k, os, es);
                end
                total++;
                if (osc !== 16'(sc[k]) || ofc !== 16'(fc[k])) begin
                    bad++; $display("FAIL rand_cnt n=%0d dut%0d: got %0d/%0d want %0d/%0d",
                                    n, k, osc, ofc, sc[k], fc[k]);
                end
                if (e == FROZEN || e == STALL) sc[k] = (sc[k] < 65535) ? sc[k] + 1 : sc[k];
                if (e == FLUSH) fc[k] = (fc[k] < 65535) ? fc[k] + 1 : fc[k];
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_load_stall3();
        test_branch_priority();
        test_busy_in_bubble();
        test_reset_mid_freeze();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
